load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Executes the LOAD/STORE operations selected by Decode. Uses the ALU result as the byte address.
//  Drives a single-outstanding req/gnt/rvalid data-memory port with byte enables and lane-aligned
//  write data. Returns sign/zero-extended load data to Decode's writeback mux (mem_data_ip/mem_data_valid_ip).
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT_RVALID before abort with lsu_err_op; 0 disables timeout
// PORTS
//  clock              in   1   core clock
//  reset              in   1   asynchronous, active-low reset
//  en_lsu_ip          in   1   Decode requests a memory operation
//  lsu_operator_ip    in   load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW
//  addr_ip            in   32  byte address (ALU result)
//  addr_valid_ip      in   1   addr_ip valid (ALU result valid)
//  wdata_ip           in   32  store data (rs2), low bits significant for SB/SH
//  mem_data_op        out  32  extended load result to regfile writeback
//  mem_data_valid_op  out  1   1-cycle pulse: mem_data_op valid (loads only)
//  store_done_op      out  1   1-cycle pulse: store completed
//  lsu_busy_op        out  1   state != IDLE; upstream holds request stable
//  lsu_err_op         out  1   1-cycle pulse: timeout (or misalign, see CONFIGURATION)
//  data_req_op        out  1   memory request
//  data_addr_op       out  32  word-aligned address {addr[31:2],2'b00}
//  data_we_op         out  1   1 = store
//  data_be_op         out  4   byte enables
//  data_wdata_op      out  32  lane-replicated store data
//  data_gnt_ip        in   1   memory accepted request
//  data_rvalid_ip     in   1   response valid (read data / write ack)
//  data_rdata_ip      in   32  read data word
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; timeout counter 0. Reset mid-transaction abandons it, no pulses.
//  FSM IDLE -> REQ -> WAIT_RVALID -> IDLE.
//   IDLE: en_lsu_ip && addr_valid_ip -> latch op/addr/wdata, go REQ. Inputs ignored outside IDLE.
//   REQ: data_req_op=1, addr/we/be/wdata held stable from latched values until data_gnt_ip.
//        gnt sampled high -> WAIT_RVALID (req drops next cycle).
//   WAIT_RVALID: rvalid not expected in the gnt cycle; on data_rvalid_ip -> IDLE with
//        load: mem_data_op registered, mem_data_valid_op=1 for one cycle; store: store_done_op=1.
//        mem_data_op holds its last value until the next load completes.
//  Min latency: accept cycle +1 REQ, gnt same cycle, rvalid next -> result valid 3 cycles after accept.
//  Byte enables / write data, a = addr[1:0]:
//   SB: be=4'b0001<<a, wdata={4{wdata_ip[7:0]}}; SH: be=4'b0011<<{a[1],1'b0}, wdata={2{wdata_ip[15:0]}};
//   SW: be=4'b1111, wdata=wdata_ip. Loads: we=0, be as for same size.
//  Load extract: s=data_rdata_ip>>(8*a); LB sext s[7:0], LBU zext s[7:0], LH sext s[15:0],
//   LHU zext s[15:0], LW s. For halfwords a[0] ignored (shift uses {a[1],1'b0}).
//  Timeout: counter increments each WAIT_RVALID cycle, clears on entry. Reaching TIMEOUT_CYCLES ->
//   lsu_err_op pulse, no data/done pulse, -> IDLE. Late rvalid arriving in IDLE is ignored.
//  Unknown lsu_operator_ip with en_lsu_ip: treated as no-op, stays IDLE.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, or LW/SW with a!=0, are not issued.
//   Stay IDLE, lsu_err_op=1 next cycle, no memory request.
//  Undefined: misaligned low bits silently dropped (halfword uses a[1], word uses a=0); no error.
// TESTING
//  SW addr=0x100 wdata=0xDEADBEEF, gnt+1 rvalid -> addr_op=0x100 be=1111, store_done_op 1 pulse.
//  LB addr=0x103 rdata=0x80FF0011 -> be=1000, mem_data_op=0xFFFFFF80; LBU same -> 0x00000080.
//  LH addr=0x102 rdata=0x8001xxxx -> mem_data_op=0xFFFF8001; SH addr=0x102 wdata=0x1234 -> be=1100 wdata=0x12341234.
//  gnt withheld 5 cycles -> req/addr/be stable all 5 cycles; en_lsu_ip pulses while busy ignored.
//  No rvalid, TIMEOUT_CYCLES=255 -> lsu_err_op pulse after 255 WAIT cycles, back IDLE; reset mid-REQ -> req=0.
//  LW addr=0x101: with LSU_MISALIGN_TRAP_EN -> no req, lsu_err_op pulse; without -> addr_op=0x100, be=1111.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Executes LOAD/STORE operations from Decode on a single-outstanding
//   req/gnt/rvalid data-memory port. The ALU result is the byte address.
//   Store data is replicated across byte lanes. Load data is extracted from
//   the addressed lane and sign/zero-extended for the writeback mux.
//
// Parameters
//   TIMEOUT_CYCLES : max WAIT_RVALID cycles before abort (0 disables)
//
// Optional feature
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned LH/LHU/SH/LW/SW are not
//                          issued and raise lsu_err_op instead.
//
// Ports
//   clock, reset (async, active-low)
//   en_lsu_ip, lsu_operator_ip, addr_ip, addr_valid_ip, wdata_ip : request
//   mem_data_op, mem_data_valid_op, store_done_op                : results
//   lsu_busy_op, lsu_err_op                                      : status
//   data_req_op, data_addr_op, data_we_op, data_be_op,
//   data_wdata_op, data_gnt_ip, data_rvalid_ip, data_rdata_ip    : memory
//
// Operator encoding (lsu_operator_ip): bit3 = store, bit2 = unsigned,
// bits[1:0] = size (0 byte, 1 half, 2 word).
//   LB=0 LH=1 LW=2 LBU=4 LHU=5 SB=8 SH=9 SW=10; anything else is a no-op.
//
// state       | meaning
// S_IDLE      | waiting for a request from Decode
// S_REQ       | data_req_op asserted, waiting for data_gnt_ip
// S_WAIT      | request granted, waiting for data_rvalid_ip or timeout
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_lsu_ip,
  input  logic [3:0]  lsu_operator_ip,
  input  logic [31:0] addr_ip,
  input  logic        addr_valid_ip,
  input  logic [31:0] wdata_ip,
  output logic [31:0] mem_data_op,
  output logic        mem_data_valid_op,
  output logic        store_done_op,
  output logic        lsu_busy_op,
  output logic        lsu_err_op,
  output logic        data_req_op,
  output logic [31:0] data_addr_op,
  output logic        data_we_op,
  output logic [3:0]  data_be_op,
  output logic [31:0] data_wdata_op,
  input  logic        data_gnt_ip,
  input  logic        data_rvalid_ip,
  input  logic [31:0] data_rdata_ip
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_tcnt;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;

  logic        w_known, w_trap, w_accept, w_trap_err, w_timeout;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_ext;
  logic        w_valid_nxt, w_done_nxt, w_err_nxt;

  // Request decode: lane-adjusted offset, byte enables and replicated data.
  always_comb begin
    w_known = 1'b0;
    case (lsu_operator_ip)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
    w_lane  = 2'b00;
    w_be    = 4'b1111;
    w_wdata = wdata_ip;
    case (lsu_operator_ip[1:0])
      2'd0: begin
        w_lane  = addr_ip[1:0];
        w_be    = 4'b0001 << addr_ip[1:0];
        w_wdata = {4{wdata_ip[7:0]}};
      end
      2'd1: begin
        w_lane  = {addr_ip[1], 1'b0};
        w_be    = 4'b0011 << {addr_ip[1], 1'b0};
        w_wdata = {2{wdata_ip[15:0]}};
      end
      default: begin
        w_lane  = 2'b00;
        w_be    = 4'b1111;
        w_wdata = wdata_ip;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    w_trap = ((lsu_operator_ip[1:0] == 2'd1) && addr_ip[0]) ||
             ((lsu_operator_ip[1:0] == 2'd2) && (addr_ip[1:0] != 2'b00));
`else
    w_trap = 1'b0;
`endif
    w_accept   = en_lsu_ip && addr_valid_ip && w_known && !w_trap;
    w_trap_err = en_lsu_ip && addr_valid_ip && w_known && w_trap;
  end

  // Load extract from the lane captured at accept time.
  always_comb begin
    w_shifted = data_rdata_ip >> {r_lane, 3'b000};
    case (r_size)
      2'd0:    w_ext = r_unsigned ? {24'd0, w_shifted[7:0]}
                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ext = r_unsigned ? {16'd0, w_shifted[15:0]}
                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_tcnt == CW'(TLAST));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
      S_REQ:   if (data_gnt_ip) w_state_nxt = S_WAIT;
      S_WAIT:  if (data_rvalid_ip || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; rvalid wins over a timeout landing in the same cycle.
  always_comb begin
    lsu_busy_op = (r_state != S_IDLE);
    data_req_op = (r_state == S_REQ);
    w_valid_nxt = (r_state == S_WAIT) && data_rvalid_ip && !data_we_op;
    w_done_nxt  = (r_state == S_WAIT) && data_rvalid_ip && data_we_op;
    w_err_nxt   = ((r_state == S_WAIT) && !data_rvalid_ip && w_timeout) ||
                  ((r_state == S_IDLE) && w_trap_err);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_data_op       <= 32'd0;
      mem_data_valid_op <= 1'b0;
      store_done_op     <= 1'b0;
      lsu_err_op        <= 1'b0;
      data_addr_op      <= 32'd0;
      data_we_op        <= 1'b0;
      data_be_op        <= 4'd0;
      data_wdata_op     <= 32'd0;
      r_size            <= 2'd0;
      r_unsigned        <= 1'b0;
      r_lane            <= 2'd0;
      r_tcnt            <= '0;
    end else begin
      mem_data_valid_op <= w_valid_nxt;
      store_done_op     <= w_done_nxt;
      lsu_err_op        <= w_err_nxt;
      if (w_valid_nxt) mem_data_op <= w_ext;
      if (r_state == S_IDLE && w_accept) begin
        data_addr_op  <= {addr_ip[31:2], 2'b00};
        data_we_op    <= lsu_operator_ip[3];
        data_be_op    <= w_be;
        data_wdata_op <= w_wdata;
        r_size        <= lsu_operator_ip[1:0];
        r_unsigned    <= lsu_operator_ip[2];
        r_lane        <= w_lane;
      end
      if (r_state == S_WAIT) r_tcnt <= r_tcnt + CW'(1);
      else                   r_tcnt <= '0;
    end
  end

endmodule
